// File: rtl/pfu_fetch.sv
// rtl/pfu_fetch.sv - Prefetch unit: sequential fetch, instruction FIFO, redirect flush (optional PFU_FETCH_ERR_EN)
module pfu_fetch #(
    parameter int unsigned       C_XLEN         = 32,
    parameter int unsigned       C_FIFO_DEPTH   = 4,
    parameter logic [C_XLEN-1:0] C_RESET_VECTOR = '0
) (
    input  logic              clk_i,
    input  logic              clk_en_i,
    input  logic              resetb_i,
    output logic              hvec_pc_ready_o,
    input  logic              hvec_pc_wr_i,
    input  logic [C_XLEN-1:0] hvec_pc_din_i,
    input  logic              imem_req_ready_i,
    output logic              imem_req_valid_o,
    output logic [C_XLEN-1:0] imem_req_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [C_XLEN-1:0] imem_rsp_data_i,
    input  logic              imem_rsp_err_i,
    output logic              ids_dav_o,
    input  logic              ids_ack_i,
    output logic [C_XLEN-1:0] ids_ins_o,
    output logic [C_XLEN-1:0] ids_pc_o,
    output logic              ids_ferr_o
);
    localparam int unsigned C_PTR_W = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
    localparam int unsigned C_CNT_W = C_PTR_W + 1;
    localparam logic [C_CNT_W:0] C_CREDIT = (C_CNT_W + 1)'(C_FIFO_DEPTH);
    localparam logic [C_XLEN-1:0] C_STEP = C_XLEN'(4);

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t              state;
    logic [C_XLEN-1:0]   fetch_pc;
    logic [C_XLEN-1:0]   rsp_pc;
    logic [C_CNT_W-1:0]  outstanding;
    logic [C_CNT_W-1:0]  discard;
    logic [C_CNT_W-1:0]  fifo_count;
    logic [C_PTR_W-1:0]  wr_ptr;
    logic [C_PTR_W-1:0]  rd_ptr;
    logic [C_XLEN-1:0]   fifo_ins [C_FIFO_DEPTH];
    logic [C_XLEN-1:0]   fifo_pc  [C_FIFO_DEPTH];
    logic [C_CNT_W:0]    credit_sum;
    logic [C_XLEN-1:0]   target_pc;
    logic                accept;
    logic                req_fire;
    logic                rsp_known;
    logic                push;
    logic                pop;
    logic                err_stop;

    // Redirect target is always word aligned
    assign target_pc        = {hvec_pc_din_i[C_XLEN-1:2], 2'b00};
    assign hvec_pc_ready_o  = (state == ST_RUN) & resetb_i;
    assign accept           = hvec_pc_wr_i & hvec_pc_ready_o & clk_en_i;
    // Every outstanding request owns a FIFO slot, so responses can never overflow
    assign credit_sum       = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_valid_o = (state == ST_RUN) & clk_en_i & resetb_i & ~hvec_pc_wr_i
                              & (credit_sum < C_CREDIT) & ~err_stop;
    assign imem_req_addr_o  = fetch_pc;
    assign req_fire         = imem_req_valid_o & imem_req_ready_i;
    // A response with nothing outstanding is a protocol violation and is ignored
    assign rsp_known        = imem_rsp_valid_i & (outstanding != '0);
    assign push             = (state == ST_RUN) & rsp_known & ~accept;
    assign ids_dav_o        = (fifo_count != '0);
    assign pop              = ids_ack_i & ids_dav_o & ~accept;
    assign ids_ins_o        = fifo_ins[rd_ptr];
    assign ids_pc_o         = fifo_pc[rd_ptr];

`ifdef PFU_FETCH_ERR_EN
    logic fifo_err [C_FIFO_DEPTH];

    assign ids_ferr_o = fifo_err[rd_ptr] & ids_dav_o;

    // Fetch halts after an errored word is buffered, until the next redirect
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            err_stop <= 1'b0;
        end else if (clk_en_i) begin
            if (accept) begin
                err_stop <= 1'b0;
            end else if (push && imem_rsp_err_i) begin
                err_stop <= 1'b1;
            end
        end
    end

    // Per-entry error flag storage
    always_ff @(posedge clk_i) begin
        if (clk_en_i && push) begin
            fifo_err[wr_ptr] <= imem_rsp_err_i;
        end
    end
`else
    logic unused_rsp_err;

    assign unused_rsp_err = imem_rsp_err_i;
    assign err_stop       = 1'b0;
    assign ids_ferr_o     = 1'b0;
`endif

    // Instruction and PC storage; validity is tracked by fifo_count
    always_ff @(posedge clk_i) begin
        if (clk_en_i && push) begin
            fifo_ins[wr_ptr] <= imem_rsp_data_i;
            fifo_pc[wr_ptr]  <= rsp_pc;
        end
    end

    // Run/flush state machine with fetch, response and FIFO bookkeeping
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state       <= ST_RUN;
            fetch_pc    <= C_RESET_VECTOR;
            rsp_pc      <= C_RESET_VECTOR;
            outstanding <= '0;
            discard     <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (clk_en_i) begin
            if (accept) begin
                fetch_pc    <= target_pc;
                rsp_pc      <= target_pc;
                outstanding <= '0;
                fifo_count  <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                discard     <= outstanding - (rsp_known ? C_CNT_W'(1) : C_CNT_W'(0));
                state       <= ((outstanding - (rsp_known ? C_CNT_W'(1) : C_CNT_W'(0))) != '0)
                               ? ST_FLUSH : ST_RUN;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + C_STEP;
                end
                if (req_fire && !push) begin
                    outstanding <= outstanding + C_CNT_W'(1);
                end else if (!req_fire && push) begin
                    outstanding <= outstanding - C_CNT_W'(1);
                end
                if (push) begin
                    rsp_pc <= rsp_pc + C_STEP;
                    wr_ptr <= wr_ptr + C_PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + C_PTR_W'(1);
                end
                if (push && !pop) begin
                    fifo_count <= fifo_count + C_CNT_W'(1);
                end else if (!push && pop) begin
                    fifo_count <= fifo_count - C_CNT_W'(1);
                end
                if (state == ST_FLUSH && imem_rsp_valid_i && discard != '0) begin
                    discard <= discard - C_CNT_W'(1);
                    if (discard == C_CNT_W'(1)) begin
                        state <= ST_RUN;
                    end
                end
            end
        end
    end
endmodule
